// File: rtl/psum_act_pool_fifo_if.sv
// ---------------------------------------------------------------------------
// psum_act_pool_fifo_if
// Streaming handshake bundle for psum_act_pool_fifo.
//   in_valid / in_ready / in_data    : psum stream from the PE column
//   out_valid / out_ready / out_data : pooled stream toward the ofmap writer
// Modports:
//   master : the side that produces input samples and consumes results
//   slave  : the pooling stage itself
// ---------------------------------------------------------------------------
interface psum_act_pool_fifo_if #(
    parameter int DATA_W = 16
) ();
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/psum_act_pool_fifo.sv
// ---------------------------------------------------------------------------
// psum_act_pool_fifo
// Downstream stage of the PE column: adds a per-channel bias with saturation,
// applies optional ReLU, max-pools POOL consecutive results and buffers the
// pooled values in a first-word-fall-through FIFO.
// Ports:
//   clk, rst   rising-edge clock, synchronous active-high reset
//   bus        slave side of the in/out valid-ready streams (signed Q8.8)
//   bias_in    bias value, captured into bias_reg when bias_load is high
//   relu_en    force negative results to zero (sampled at accept)
//   flush      drop the partial pool group and the stage-1 sample
//   count      FIFO occupancy; full / empty derived from it
//   sat_flag   sticky: a bias add saturated or a FIFO write was dropped
// ---------------------------------------------------------------------------
module psum_act_pool_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,   // power of 2, >= 4
    parameter int POOL   = 2    // 1..4
) (
    input  logic                   clk,
    input  logic                   rst,
    psum_act_pool_fifo_if.slave    bus,
    input  logic [DATA_W-1:0]      bias_in,
    input  logic                   bias_load,
    input  logic                   relu_en,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    output logic                   sat_flag
);
    localparam int              AW            = $clog2(DEPTH);
    localparam int              CW            = AW + 1;
    localparam logic [CW-1:0]   CNT_FULL      = CW'(DEPTH);
    localparam logic [CW-1:0]   CNT_READY_MAX = CW'(DEPTH - 2);
    localparam logic [1:0]      POOL_LAST     = 2'(POOL - 1);

    logic signed [DATA_W-1:0] bias_reg;
    logic                     accept;
    logic signed [DATA_W:0]   sum_ext;
    logic                     sat_hi;
    logic                     sat_lo;
    logic signed [DATA_W-1:0] s1_next;
    logic                     s1_valid;
    logic signed [DATA_W-1:0] s1_data;
    logic [1:0]               pool_cnt;
    logic signed [DATA_W-1:0] max_reg;
    logic signed [DATA_W-1:0] pool_max;
    logic                     fifo_wr;
    logic                     fifo_rd;
    logic                     wr_ok;
    logic                     wr_drop;
    logic [DATA_W-1:0]        mem [DEPTH];
    logic [AW-1:0]            wr_ptr;
    logic [AW-1:0]            rd_ptr;

    // Ready only leaves room for the one result still in stage 1.
    assign bus.in_ready = (count <= CNT_READY_MAX);
    assign accept       = bus.in_valid && bus.in_ready;

    // ---------------- Stage 1: bias add, saturate, ReLU ----------------
    // One guard bit: the two top bits disagree exactly on overflow.
    assign sum_ext = {bus.in_data[DATA_W-1], bus.in_data} + {bias_reg[DATA_W-1], bias_reg};
    assign sat_hi  = (sum_ext[DATA_W:DATA_W-1] == 2'b01);
    assign sat_lo  = (sum_ext[DATA_W:DATA_W-1] == 2'b10);

    always_comb begin
        // NOTE: default first so every path assigns s1_next and no latch is inferred.
        s1_next = sum_ext[DATA_W-1:0];
        if (sat_hi) begin
            s1_next = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (sat_lo) begin
            s1_next = {1'b1, {(DATA_W-1){1'b0}}};
        end
        if (relu_en && s1_next[DATA_W-1]) begin
            s1_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so all registers update from pre-edge values.
        if (rst) begin
            bias_reg <= '0;
        end else if (bias_load) begin
            bias_reg <= bias_in;
        end
    end

    // A sample accepted on a flush edge is kept; flush only gates stage 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_data <= s1_next;
            end
        end
    end

    // ---------------- Stage 2: max pool ----------------
    always_comb begin
        pool_max = s1_data;
        if ((pool_cnt != 2'd0) && (max_reg > s1_data)) begin
            pool_max = max_reg;
        end
    end

    assign fifo_wr = s1_valid && !flush && (pool_cnt == POOL_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            pool_cnt <= 2'd0;
            max_reg  <= '0;
        end else if (flush) begin
            pool_cnt <= 2'd0;
        end else if (s1_valid) begin
            max_reg  <= pool_max;
            pool_cnt <= (pool_cnt == POOL_LAST) ? 2'd0 : pool_cnt + 2'd1;
        end
    end

    // ---------------- FWFT FIFO ----------------
    assign fifo_rd = bus.out_ready && !empty;
    // A write into a full FIFO is still legal when the head leaves on the same edge.
    assign wr_ok   = fifo_wr && (!full || fifo_rd);
    assign wr_drop = fifo_wr && full && !fifo_rd;

    // NOTE: storage has no reset; empty masks stale entries and keeps it RAM-mappable.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= pool_max;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (fifo_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_ok, fifo_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign full          = (count == CNT_FULL);
    assign empty         = (count == '0);
    assign bus.out_valid = !empty;
    assign bus.out_data  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            sat_flag <= 1'b0;
        end else if ((accept && (sat_hi || sat_lo)) || wr_drop) begin
            sat_flag <= 1'b1;
        end
    end
endmodule
